// File: rtl/alu_sequencer_pkg.sv
// Shared constants and types for the ALU issue/writeback sequencer:
// opcodes, ALU control encodings, FSM states, flag bit positions.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_ORN   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_ANDN  = 4'h5;
    localparam logic [3:0] OP_NOTA  = 4'h6;
    localparam logic [3:0] OP_NOTB  = 4'h7;
    localparam logic [3:0] OP_LSL   = 4'h8;
    localparam logic [3:0] OP_LSR   = 4'h9;
    localparam logic [3:0] OP_PASSA = 4'hA;
    localparam logic [3:0] OP_PASSB = 4'hB;
    localparam logic [3:0] OP_CMP   = 4'hC;
    localparam logic [3:0] OP_NEG   = 4'hD;
    localparam logic [3:0] OP_ROL   = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hF;

    localparam logic [2:0] CTRL_ADD   = 3'b000;
    localparam logic [2:0] CTRL_OR    = 3'b001;
    localparam logic [2:0] CTRL_AND   = 3'b010;
    localparam logic [2:0] CTRL_NOT   = 3'b011;
    localparam logic [2:0] CTRL_SHIFT = 3'b100;
    localparam logic [2:0] CTRL_PASS  = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_ROL2 = 3'd2,
        S_ROL3 = 3'd3,
        S_RESP = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       cin;
        logic       force_a_zero;
        logic       multipass;
        logic       arith_flags;
        logic       wr;
        logic       illegal;
    } dec_t;

    function automatic logic [3:0] make_flags(input logic c, input logic v,
                                              input logic z, input logic n);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus between instruction decode (master) and the sequencer (slave).
// Both channels are strict valid/ready: a transfer happens on a rising edge where
// valid & ready are both high; once raised, valid and its payload stay put until then.
interface alu_sequencer_if #(parameter int N = 4);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_f;
    logic         rsp_wr;
    logic         rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_wr, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_wr, rsp_err
    );
endinterface

// File: rtl/alu_sequencer_op_decode.sv
// Combinational opcode decoder: opcode -> ALU ctrl/cin plus sequencing attributes.
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] op,
    output dec_t       dec
);

    always_comb begin
        dec      = '0;
        dec.ctrl = CTRL_PASS;
        dec.wr   = 1'b1;
        case (op)
            OP_ADD:   begin dec.ctrl = CTRL_ADD; dec.arith_flags = 1'b1; end
            OP_SUB:   begin dec.ctrl = CTRL_ADD; dec.cin = 1'b1; dec.arith_flags = 1'b1; end
            OP_OR:    dec.ctrl = CTRL_OR;
            OP_ORN:   begin dec.ctrl = CTRL_OR; dec.cin = 1'b1; end
            OP_AND:   dec.ctrl = CTRL_AND;
            OP_ANDN:  begin dec.ctrl = CTRL_AND; dec.cin = 1'b1; end
            OP_NOTA:  dec.ctrl = CTRL_NOT;
            OP_NOTB:  begin dec.ctrl = CTRL_NOT; dec.cin = 1'b1; end
            OP_LSL:   dec.ctrl = CTRL_SHIFT;
            OP_LSR:   begin dec.ctrl = CTRL_SHIFT; dec.cin = 1'b1; end
            OP_PASSA: dec.ctrl = CTRL_PASS;
            OP_PASSB: begin dec.ctrl = CTRL_PASS; dec.cin = 1'b1; end
            OP_CMP: begin
                dec.ctrl        = CTRL_ADD;
                dec.cin         = 1'b1;
                dec.arith_flags = 1'b1;
                dec.wr          = 1'b0;
            end
            OP_NEG: begin
                dec.ctrl         = CTRL_ADD;
                dec.cin          = 1'b1;
                dec.arith_flags  = 1'b1;
                dec.force_a_zero = 1'b1;
            end
            // ROL's first pass is a plain LSL; the later passes are sequenced by the FSM.
            OP_ROL: begin
                dec.ctrl      = CTRL_SHIFT;
                dec.multipass = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
                dec.wr      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the external combinational ALU: accepts one
// request, sequences one or three ALU passes, registers result and {C,V,Z,N}.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_sequencer_if.slave bus,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic          alu_cin,
    output logic [2:0]    alu_ctrl,
    input  logic [N-1:0]  alu_f,
    input  logic          alu_cout,
    input  logic          alu_v,
    input  logic          alu_z,
    output logic [3:0]    flags,
    output state_t        dbg_state
);

    state_t       state;
    state_t       state_next;
    logic [3:0]   op_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] tmp;
    logic [N-1:0] tmp2;
    logic [N-1:0] f_q;
    logic         wr_q;
    logic         err_q;
    logic [3:0]   flags_q;
    logic [M-1:0] rol_back;
    dec_t         dec;

    alu_op_decode u_decode (
        .op  (op_q),
        .dec (dec)
    );

    // Right-shift amount for the wrap-around half of a rotate; N is a power of two.
    assign rol_back = -b_q[M-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        alu_ctrl   = CTRL_PASS;
        alu_cin    = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            S_IDLE: if (bus.req_valid) state_next = S_EXEC;
            S_EXEC: begin
                if (!dec.illegal) begin
                    alu_ctrl = dec.ctrl;
                    alu_cin  = dec.cin;
                    alu_a    = dec.force_a_zero ? '0 : a_q;
                    alu_b    = b_q;
                end
                state_next = dec.multipass ? S_ROL2 : S_RESP;
            end
            S_ROL2: begin
                alu_ctrl   = CTRL_SHIFT;
                alu_cin    = 1'b1;
                alu_a      = a_q;
                alu_b      = {{(N-M){1'b0}}, rol_back};
                state_next = S_ROL3;
            end
            S_ROL3: begin
                alu_ctrl   = CTRL_OR;
                alu_a      = tmp;
                alu_b      = tmp2;
                state_next = S_RESP;
            end
            S_RESP: if (bus.rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tmp     <= '0;
            tmp2    <= '0;
            f_q     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                    end
                end
                S_EXEC: begin
                    if (dec.illegal) begin
                        f_q   <= '0;
                        wr_q  <= 1'b0;
                        err_q <= 1'b1;
                    end else if (dec.multipass) begin
                        tmp <= alu_f;
                    end else begin
                        f_q     <= alu_f;
                        wr_q    <= dec.wr;
                        err_q   <= 1'b0;
                        flags_q <= make_flags(dec.arith_flags & alu_cout,
                                              dec.arith_flags & alu_v,
                                              alu_z, alu_f[N-1]);
                    end
                end
                S_ROL2: tmp2 <= alu_f;
                S_ROL3: begin
                    f_q     <= alu_f;
                    wr_q    <= 1'b1;
                    err_q   <= 1'b0;
                    flags_q <= make_flags(1'b0, 1'b0, alu_z, alu_f[N-1]);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_f     = f_q;
    assign bus.rsp_wr    = wr_q;
    assign bus.rsp_err   = err_q;
    assign flags         = flags_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, opcode-level reference model with an
// expected-response queue, and directed vectors with hand-computed results.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int N = 4;
    localparam int M = 2;
    localparam int W = N + 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_sequencer_if #(.N(N)) bus ();

    logic [N-1:0] alu_a, alu_b, alu_f;
    logic         alu_cin, alu_cout, alu_v, alu_z;
    logic [2:0]   alu_ctrl;
    logic [3:0]   flags;
    state_t       dbg_state;

    alu_sequencer #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_ctrl  (alu_ctrl),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    // External ALU stand-in
    logic [N-1:0] m_bb;
    logic [N:0]   m_sum;
    always_comb begin
        m_bb     = alu_cin ? ~alu_b : alu_b;
        m_sum    = {1'b0, alu_a} + {1'b0, m_bb} + {{N{1'b0}}, alu_cin};
        alu_f    = '0;
        alu_cout = 1'b0;
        alu_v    = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                alu_f    = m_sum[N-1:0];
                alu_cout = m_sum[N];
                alu_v    = (alu_a[N-1] == m_bb[N-1]) && (m_sum[N-1] != alu_a[N-1]);
            end
            3'b001: alu_f = alu_a | m_bb;
            3'b010: alu_f = alu_a & m_bb;
            3'b011: alu_f = alu_cin ? ~alu_b : ~alu_a;
            3'b100: alu_f = alu_cin ? (alu_a >> alu_b[M-1:0]) : (alu_a << alu_b[M-1:0]);
            3'b111: alu_f = alu_cin ? alu_b : alu_a;
            default: alu_f = '0;
        endcase
        alu_z = (alu_f == '0);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Opcode-level reference: result as {f, wr, err, flags{C,V,Z,N}}
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic [3:0] fl_in);
        int ua, ub, r, s, sa, sb, sres;
        logic [N-1:0] f;
        logic c, v, wr, err, arith;
        logic [3:0] fl;
        ua = int'(a); ub = int'(b); s = ub % N;
        c = 1'b0; v = 1'b0; wr = 1'b1; err = 1'b0; arith = 1'b0; f = '0;
        if (op == 4'hD) ua = 0;
        sa = (ua >= 2**(N-1)) ? ua - 2**N : ua;
        sb = (ub >= 2**(N-1)) ? ub - 2**N : ub;
        case (op)
            4'h0: begin
                r = ua + ub; f = r[N-1:0]; c = (r >= 2**N); arith = 1'b1;
                sres = sa + sb; v = (sres < -(2**(N-1))) || (sres > 2**(N-1) - 1);
            end
            4'h1, 4'hC, 4'hD: begin
                r = ua - ub; f = r[N-1:0]; c = (ua >= ub); arith = 1'b1;
                sres = sa - sb; v = (sres < -(2**(N-1))) || (sres > 2**(N-1) - 1);
                wr = (op != 4'hC);
            end
            4'h2: f = a | b;
            4'h3: f = a | ~b;
            4'h4: f = a & b;
            4'h5: f = a & ~b;
            4'h6: f = ~a;
            4'h7: f = ~b;
            4'h8: f = a << s;
            4'h9: f = a >> s;
            4'hA: f = a;
            4'hB: f = b;
            4'hE: f = (a << s) | (a >> (N - s));
            default: begin wr = 1'b0; err = 1'b1; end
        endcase
        if (err) fl = fl_in;
        else     fl = {arith & c, arith & v, (f == '0), f[N-1]};
        return {f, wr, err, fl};
    endfunction

    // Scoreboard: predict on accept, compare every cycle a response is presented
    logic [W-1:0] exp_q[$];
    logic [3:0]   m_flags = '0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_flags = '0;
        end else begin
            if (bus.req_ready)
                check("alu_idle", {alu_ctrl, alu_cin, alu_a, alu_b}, {3'b111, 1'b0, {(2*N){1'b0}}});
            if (bus.req_valid && bus.req_ready) begin
                e = model(bus.req_op, bus.req_a, bus.req_b, m_flags);
                exp_q.push_back(e);
                m_flags = e[3:0];
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    check("sb_rsp", {bus.rsp_f, bus.rsp_wr, bus.rsp_err, flags}, exp_q[0]);
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct packed {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] f;
        logic [3:0]   fl;
        logic         wr;
        logic [3:0]   lat;
    } vec_t;

    vec_t vecs[$];

    // Returns at the negedge on which rsp_valid is first seen; lat = edges after accept.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat);
        bit acc = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk); acc = bus.req_ready;
            @(posedge clk);
        end
        #1 bus.req_valid = 1'b0;
        lat = 0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_rsp(input int idx);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_req_ready_after", idx), bus.req_ready, 1);
        check($sformatf("v%0d_valid_drop", idx), bus.rsp_valid, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        issue(v.op, v.a, v.b, lat);
        check($sformatf("v%0d_lat", idx), lat, v.lat);
        check($sformatf("v%0d_f", idx), bus.rsp_f, v.f);
        check($sformatf("v%0d_flags", idx), flags, v.fl);
        check($sformatf("v%0d_wr", idx), bus.rsp_wr, v.wr);
        check($sformatf("v%0d_err", idx), bus.rsp_err, (v.op == 4'hF));
        finish_rsp(idx);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_f", bus.rsp_f, 0);
        check("rst_rsp_wr", bus.rsp_wr, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_flags", flags, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;

        //                op    a      b      f      flags   wr  lat
        vecs.push_back('{4'h0, 4'h7, 4'h1, 4'h8, 4'b0101, 1'b1, 4'd1});  // ADD overflow
        vecs.push_back('{4'h1, 4'h3, 4'h3, 4'h0, 4'b1010, 1'b1, 4'd1});  // SUB zero
        vecs.push_back('{4'hC, 4'h2, 4'h5, 4'hD, 4'b0001, 1'b0, 4'd1});  // CMP
        vecs.push_back('{4'hE, 4'h9, 4'h1, 4'h3, 4'b0000, 1'b1, 4'd3});  // ROL by 1
        vecs.push_back('{4'hE, 4'h9, 4'h0, 4'h9, 4'b0001, 1'b1, 4'd3});  // ROL by 0
        vecs.push_back('{4'hE, 4'h9, 4'h3, 4'hC, 4'b0001, 1'b1, 4'd3});  // ROL by 3
        vecs.push_back('{4'hD, 4'h5, 4'h3, 4'hD, 4'b0001, 1'b1, 4'd1});  // NEG ignores a
        vecs.push_back('{4'hD, 4'h0, 4'h0, 4'h0, 4'b1010, 1'b1, 4'd1});  // NEG 0
        vecs.push_back('{4'h1, 4'h8, 4'h1, 4'h7, 4'b1100, 1'b1, 4'd1});  // SUB overflow
        vecs.push_back('{4'h0, 4'hF, 4'h1, 4'h0, 4'b1010, 1'b1, 4'd1});  // ADD carry
        vecs.push_back('{4'h9, 4'h8, 4'h2, 4'h2, 4'b0000, 1'b1, 4'd1});  // LSR
        vecs.push_back('{4'h8, 4'h3, 4'h3, 4'h8, 4'b0001, 1'b1, 4'd1});  // LSL
        vecs.push_back('{4'h8, 4'h1, 4'h5, 4'h2, 4'b0000, 1'b1, 4'd1});  // LSL uses b[M-1:0]
        vecs.push_back('{4'h3, 4'h0, 4'hF, 4'h0, 4'b0010, 1'b1, 4'd1});  // ORN
        vecs.push_back('{4'h5, 4'hF, 4'h5, 4'hA, 4'b0001, 1'b1, 4'd1});  // ANDN
        vecs.push_back('{4'h7, 4'h0, 4'h0, 4'hF, 4'b0001, 1'b1, 4'd1});  // NOTB
        vecs.push_back('{4'h6, 4'hF, 4'h0, 4'h0, 4'b0010, 1'b1, 4'd1});  // NOTA
        vecs.push_back('{4'hB, 4'h0, 4'h6, 4'h6, 4'b0000, 1'b1, 4'd1});  // PASSB
        vecs.push_back('{4'hA, 4'h5, 4'h0, 4'h5, 4'b0000, 1'b1, 4'd1});  // PASSA
        vecs.push_back('{4'h2, 4'h1, 4'h2, 4'h3, 4'b0000, 1'b1, 4'd1});  // OR
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: response held for 5 cycles
        bus.rsp_ready = 1'b0;
        issue(4'h4, 4'hC, 4'hA, lat);
        check("bp_lat", lat, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_f", bus.rsp_f, 4'h8);
            check("bp_wr", bus.rsp_wr, 1);
            check("bp_flags", flags, 4'b0001);
            check("bp_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        finish_rsp(100);

        // Illegal opcode leaves flags from the AND above
        run_vec('{4'hF, 4'h3, 4'h4, 4'h0, 4'b0001, 1'b0, 4'd1}, 101);

        // Reset while ROL is in its second pass
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = 4'hE; bus.req_a = 4'h9; bus.req_b = 4'h1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_state_rol2", dbg_state, S_ROL2);
        check("mid_flags_before", flags, 4'b0001);
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        check("mid_rsp_valid", bus.rsp_valid, 0);
        check("mid_flags_cleared", flags, 0);
        check("mid_state_idle", dbg_state, S_IDLE);
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_rsp", bus.rsp_valid, 0);
            check("post_rst_idle", bus.req_ready, 1);
        end
        run_vec('{4'h0, 4'h1, 4'h1, 4'h2, 4'b0000, 1'b1, 4'd1}, 102);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
